block_map_write_arbiter: RTL and testbench

//  Owns the single write port of the block map RAM (33x27 tiles, 891 entries).

---
 rtl/block_map_write_arbiter.sv | 128 ++++++++++++
 tb/tb_block_map_write_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_map_write_arbiter.sv
// rtl/block_map_write_arbiter.sv - block map RAM write port owner: ROM map load plus round-robin requester arbitration
module block_map_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 2,
    parameter int MAP_DEPTH = 891
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_init_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]  req_data_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [ADDR_W-1:0]        rom_addr_o,
    input  logic [DATA_W-1:0]        rom_data_i,
    output logic                     ram_we_o,
    output logic [ADDR_W-1:0]        ram_addr_o,
    output logic [DATA_W-1:0]        ram_din_o,
    output logic                     init_done_o,
    output logic                     err_oob_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_V = ADDR_W'(MAP_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_V  = ADDR_W'(MAP_DEPTH - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_FLUSH = 2'd1,
        S_IDLE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                ram_we_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_din_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic                init_done_q;
    logic                err_oob_q;

    logic                gnt_any_d;
    logic [PTR_W-1:0]    gnt_idx_d;
    logic [PTR_W-1:0]    cand_d;
    logic [N_REQ-1:0]    gnt_d;
    logic [ADDR_W-1:0]   gnt_addr_d;
    logic [DATA_W-1:0]   gnt_data_d;
    logic                gnt_oob_d;

    // Round-robin search starting one past the last winner; a reload request blocks all grants
    always_comb begin
        gnt_any_d = 1'b0;
        gnt_idx_d = '0;
        cand_d    = '0;
        if (state_q == S_IDLE && !start_init_i) begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand_d = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
                if (!gnt_any_d && req_i[cand_d]) begin
                    gnt_any_d = 1'b1;
                    gnt_idx_d = cand_d;
                end
            end
        end
        gnt_d      = gnt_any_d ? (N_REQ'(1) << gnt_idx_d) : '0;
        gnt_addr_d = req_addr_i[int'(gnt_idx_d)*ADDR_W +: ADDR_W];
        gnt_data_d = req_data_i[int'(gnt_idx_d)*DATA_W +: DATA_W];
        gnt_oob_d  = (gnt_addr_d >= DEPTH_V);
    end

    // Load sequencer and registered write port; writes trail the ROM address by one cycle during a load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_INIT;
            rom_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            rr_ptr_q    <= PTR_W'(N_REQ - 1);
            init_done_q <= 1'b0;
            err_oob_q   <= 1'b0;
        end else begin
            ram_we_q  <= 1'b0;
            err_oob_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    ram_we_q   <= 1'b1;
                    ram_addr_q <= rom_addr_q;
                    if (rom_addr_q == LAST_V) begin
                        state_q <= S_FLUSH;
                    end else begin
                        rom_addr_q <= rom_addr_q + 1'b1;
                    end
                end
                S_FLUSH: begin
                    state_q     <= S_IDLE;
                    init_done_q <= 1'b1;
                end
                S_IDLE: begin
                    if (start_init_i) begin
                        state_q     <= S_INIT;
                        rom_addr_q  <= '0;
                        init_done_q <= 1'b0;
                    end else if (gnt_any_d) begin
                        rr_ptr_q <= gnt_idx_d;
                        if (gnt_oob_d) begin
                            err_oob_q <= 1'b1;
                        end else begin
                            ram_we_q   <= 1'b1;
                            ram_addr_q <= gnt_addr_d;
                            ram_din_q  <= gnt_data_d;
                        end
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign gnt_o       = gnt_d;
    assign rom_addr_o  = rom_addr_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_din_o   = (state_q == S_IDLE) ? ram_din_q : rom_data_i;
    assign init_done_o = init_done_q;
    assign err_oob_o   = err_oob_q;

endmodule

// File: tb/tb_block_map_write_arbiter.sv
// tb/tb_block_map_write_arbiter.sv - self-checking bench for block_map_write_arbiter
module tb_block_map_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_init;
    logic [3:0]  req;
    logic [39:0] req_addr;
    logic [7:0]  req_data;
    logic [3:0]  gnt;
    logic [9:0]  rom_addr;
    logic [1:0]  rom_data;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [1:0]  ram_din;
    logic        init_done;
    logic        err_oob;

    int checks   = 0;
    int failures = 0;

    logic [11:0] wq[$];

    logic [3:0]  s_gnt;
    logic        s_we;
    logic [9:0]  s_addr;
    logic [1:0]  s_din;
    logic        s_err;
    logic        s_done;
    logic [9:0]  s_rom;

    block_map_write_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .start_init_i (start_init),
        .req_i        (req),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .gnt_o        (gnt),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_din_o    (ram_din),
        .init_done_o  (init_done),
        .err_oob_o    (err_oob)
    );

    always #5 clk = ~clk;

    // Synchronous init ROM whose content is the low two address bits
    always @(posedge clk) rom_data <= rom_addr[1:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [11:0] e;
        @(negedge clk);
        s_gnt  = gnt;
        s_we   = ram_we;
        s_addr = ram_addr;
        s_din  = ram_din;
        s_err  = err_oob;
        s_done = init_done;
        s_rom  = rom_addr;
        if (s_we === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_write observed=%0h expected=none", {s_addr, s_din});
            end else begin
                e = wq.pop_front();
                chk("write", {20'd0, s_addr, s_din}, {20'd0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_load();
        for (int a = 0; a < 891; a++) begin
            logic [9:0] av;
            av = a[9:0];
            wq.push_back({av, av[1:0]});
        end
    endtask

    task automatic run_load(input string tag);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        while (n < 2000) begin
            step();
            if (s_done === 1'b1) break;
            if (s_gnt !== 4'b0000) bad++;
            n++;
        end
        chk({tag, "_cycles"}, n, 892);
        chk({tag, "_gnt_zero"}, bad, 0);
        chk({tag, "_all_written"}, wq.size(), 0);
    endtask

    task automatic set_req(input int i, input logic [9:0] a, input logic [1:0] d);
        req[i]              = 1'b1;
        req_addr[i*10 +: 10] = a;
        req_data[i*2 +: 2]   = d;
    endtask

    initial begin
        int n;
        int bad;
        reset      = 1'b1;
        start_init = 1'b0;
        req        = '0;
        req_addr   = '0;
        req_data   = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_err", err_oob, 0);

        // Load after reset, with all four requesters already waiting
        for (int i = 0; i < 4; i++) begin
            logic [9:0] a;
            logic [1:0] d;
            a = 10'(10 + 7 * i);
            d = 2'(i + 1);
            set_req(i, a, d);
        end
        push_load();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_load("load1");

        // Round-robin from rr_ptr=3 over four requesters, each dropping on grant
        for (int i = 0; i < 4; i++) begin
            logic [9:0] a;
            logic [1:0] d;
            a = 10'(10 + 7 * i);
            d = 2'(i + 1);
            chk("rr4_gnt", s_gnt, 4'b0001 << i);
            wq.push_back({a, d});
            req[i] = 1'b0;
            step();
        end
        chk("rr4_gnt_after", s_gnt, 0);

        // Two requesters held continuously alternate
        set_req(0, 10'd100, 2'd1);
        set_req(1, 10'd200, 2'd2);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("alt_gnt", s_gnt, (i % 2 == 0) ? 4'b0001 : 4'b0010);
            wq.push_back((i % 2 == 0) ? {10'd100, 2'd1} : {10'd200, 2'd2});
        end
        req = '0;
        step();
        chk("idle_gnt", s_gnt, 0);
        step();
        chk("idle_we", s_we, 0);

        // Out-of-range address is consumed without a write
        set_req(0, 10'd900, 2'd1);
        step();
        chk("oob_gnt", s_gnt, 4'b0001);
        req = '0;
        step();
        chk("oob_we", s_we, 0);
        chk("oob_err", s_err, 1);
        step();
        chk("oob_err_pulse", s_err, 0);

        // Reload request beats a simultaneous write request
        set_req(2, 10'd5, 2'd2);
        start_init = 1'b1;
        step();
        chk("si_gnt", s_gnt, 0);
        start_init = 1'b0;
        push_load();
        run_load("load2");
        chk("si_post_gnt", s_gnt, 4'b0100);
        wq.push_back({10'd5, 2'd2});
        req = '0;
        step();
        chk("si_post_write", wq.size(), 0);

        // Reset in the middle of a reload
        start_init = 1'b1;
        step();
        start_init = 1'b0;
        push_load();
        n = 0;
        while (s_rom !== 10'd399 && n < 2000) begin
            step();
            n++;
        end
        chk("mid_reached", s_rom, 399);
        reset = 1'b1;
        wq.delete();
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (s_we !== 1'b0 || s_rom !== 10'd0 || s_done !== 1'b0) bad++;
        end
        chk("mid_reset_quiet", bad, 0);
        push_load();
        reset = 1'b0;
        run_load("load3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
